// File: rtl/mcpu_mem_responder_if.sv
// rtl/mcpu_mem_responder_if.sv - request/response channel between CPU and memory responder
interface mcpu_mem_responder_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [31:0]      req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_rdata;
  logic             resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mcpu_mem_responder.sv
// rtl/mcpu_mem_responder.sv - wait-stated word RAM responder with range/alignment error flag
module mcpu_mem_responder #(
  parameter int WIDTH       = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  mcpu_mem_responder_if.slave bus,
  output logic                busy
);
  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic             lat_we;
  logic [31:0]      lat_addr;
  logic [WIDTH-1:0] lat_wdata;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] idx;
  logic                  err;
  logic                  commit;

  // No wrap: any set bit above the RAM's byte range is an error.
  assign idx    = lat_addr[DEPTH_LOG2+1:2];
  assign err    = (lat_addr[1:0] != 2'b00) || ((lat_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
  assign commit = (state == WAIT) && (cnt == 4'd0);

  // Reset wins over commit, so a write pending at reset never lands.
  always_ff @(posedge clk) begin
    if (!reset && commit && lat_we && !err)
      mem[idx] <= lat_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      lat_we         <= 1'b0;
      lat_addr       <= 32'd0;
      lat_wdata      <= '0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lat_we        <= bus.req_we;
            lat_addr      <= bus.req_addr;
            lat_wdata     <= bus.req_wdata;
            cnt           <= WAIT_INIT;
            state         <= WAIT;
            bus.req_ready <= 1'b0;
            busy          <= 1'b1;
          end
        end
        WAIT: begin
          if (!commit) begin
            cnt <= cnt - 4'd1;
          end else begin
            bus.resp_rdata <= (!lat_we && !err) ? mem[idx] : '0;
            bus.resp_err   <= err;
            bus.resp_valid <= 1'b1;
            state          <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.req_ready  <= 1'b1;
            busy           <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mcpu_mem_responder.sv
// tb/tb_mcpu_mem_responder.sv - directed checks for mcpu_mem_responder
module tb_mcpu_mem_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy2, busy0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mcpu_mem_responder_if #(.WIDTH(32)) bus2 ();
  mcpu_mem_responder_if #(.WIDTH(32)) bus0 ();

  mcpu_mem_responder #(.WIDTH(32), .DEPTH_LOG2(10), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave), .busy(busy2)
  );
  mcpu_mem_responder #(.WIDTH(32), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave), .busy(busy0)
  );

  // Issue one request on the WAIT_CYCLES=2 instance; leaves the response pending.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err);
    @(negedge clk);
    bus2.req_valid = 1'b1; bus2.req_we = we; bus2.req_addr = addr; bus2.req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_addr = 32'd0; bus2.req_wdata = 32'd0;
    lat = -1; rdata = 32'hx; err = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus2.resp_valid === 1'b1) begin
        lat = k; rdata = bus2.resp_rdata; err = bus2.resp_err;
        break;
      end
    end
  endtask

  task automatic ack2();
    bus2.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus2.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus2.req_ready !== 1'b1 || bus2.resp_valid !== 1'b0 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: req_ready=%b resp_valid=%b busy=%b, want 1 0 0",
               bus2.req_ready, bus2.resp_valid, busy2);
    end
    checks++;
    if (bus2.resp_rdata !== 32'd0 || bus2.resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h err=%b, want 0 0", bus2.resp_rdata, bus2.resp_err);
    end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b1, 32'h10, 32'hDEADBEEF, lat, rd, er);
    checks++;
    if (lat !== 3 || rd !== 32'd0 || er !== 1'b0) begin
      errors++;
      $display("FAIL write_resp: lat=%0d rdata=%h err=%b, want 3 0 0", lat, rd, er);
    end
    ack2();
    checks++;
    if (bus2.resp_valid !== 1'b0 || bus2.req_ready !== 1'b1 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL after_ack: resp_valid=%b req_ready=%b busy=%b, want 0 1 0",
               bus2.resp_valid, bus2.req_ready, busy2);
    end
    do_req(1'b0, 32'h10, 32'd0, lat, rd, er);
    checks++;
    if (lat !== 3 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      errors++;
      $display("FAIL read_back: lat=%0d rdata=%h err=%b, want 3 deadbeef 0", lat, rd, er);
    end
    ack2();
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] rd; logic er; int bad;
    do_req(1'b0, 32'h10, 32'd0, lat, rd, er);
    checks++;
    if (lat !== 3 || rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL bp_first: lat=%0d rdata=%h, want 3 deadbeef", lat, rd);
    end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        bus2.req_valid = 1'b1; bus2.req_we = 1'b1; bus2.req_addr = 32'h10; bus2.req_wdata = 32'h0;
      end else begin
        bus2.req_valid = 1'b0; bus2.req_we = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      if (bus2.resp_valid !== 1'b1 || bus2.resp_rdata !== 32'hDEADBEEF || bus2.resp_err !== 1'b0 ||
          bus2.req_ready !== 1'b0 || busy2 !== 1'b1) bad++;
    end
    bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_addr = 32'd0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bp_stable: %0d unstable cycles, want 0", bad);
    end
    ack2();
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus2.resp_valid !== 1'b0 || bus2.req_ready !== 1'b1) bad++;
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bp_no_second: %0d cycles with extra response/busy, want 0", bad);
    end
    do_req(1'b0, 32'h10, 32'd0, lat, rd, er);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL bp_ignored_write: rdata=%h, want deadbeef", rd);
    end
    ack2();
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b1, 32'h13, 32'h12345678, lat, rd, er);
    checks++;
    if (lat !== 3 || er !== 1'b1 || rd !== 32'd0) begin
      errors++;
      $display("FAIL misaligned: lat=%0d err=%b rdata=%h, want 3 1 0", lat, er, rd);
    end
    ack2();
    do_req(1'b0, 32'h10, 32'd0, lat, rd, er);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_nowrite: rdata=%h err=%b, want deadbeef 0", rd, er);
    end
    ack2();
    do_req(1'b0, 32'h1000, 32'd0, lat, rd, er);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      errors++;
      $display("FAIL out_of_range: err=%b rdata=%h, want 1 0", er, rd);
    end
    ack2();
    do_req(1'b0, 32'hFFC, 32'd0, lat, rd, er);
    checks++;
    if (er !== 1'b0 || lat !== 3) begin
      errors++;
      $display("FAIL top_word: err=%b lat=%0d, want 0 3", er, lat);
    end
    ack2();
  endtask

  task automatic test_reset_in_wait();
    int lat; logic [31:0] rd; logic er; int bad;
    do_req(1'b1, 32'h20, 32'h11111111, lat, rd, er);
    ack2();
    @(negedge clk);
    bus2.req_valid = 1'b1; bus2.req_we = 1'b1; bus2.req_addr = 32'h20; bus2.req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    bus2.req_valid = 1'b0; bus2.req_we = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus2.resp_valid !== 1'b0 || bus2.req_ready !== 1'b1) bad++;
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reset_abort: %0d cycles with resp_valid or !req_ready, want 0", bad);
    end
    do_req(1'b0, 32'h20, 32'd0, lat, rd, er);
    checks++;
    if (rd !== 32'h11111111 || er !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: rdata=%h err=%b, want 11111111 0", rd, er);
    end
    ack2();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus0.resp_ready = 1'b1;
    bus0.req_valid = 1'b1; bus0.req_we = 1'b1; bus0.req_addr = 32'h0; bus0.req_wdata = 32'hA5A5A5A5;
    @(posedge clk);
    @(negedge clk);
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0;
    checks++;
    if (bus0.resp_valid !== 1'b0 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: resp_valid=%b busy=%b, want 0 1", bus0.resp_valid, busy0);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus0.resp_valid !== 1'b1 || bus0.resp_err !== 1'b0 || bus0.resp_rdata !== 32'd0 ||
        bus0.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_write_resp: valid=%b err=%b rdata=%h req_ready=%b, want 1 0 0 0",
               bus0.resp_valid, bus0.resp_err, bus0.resp_rdata, bus0.req_ready);
    end
    bus0.req_valid = 1'b1; bus0.req_we = 1'b0; bus0.req_addr = 32'h0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus0.resp_valid !== 1'b0 || bus0.req_ready !== 1'b1 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_handshake: valid=%b req_ready=%b busy=%b, want 0 1 0",
               bus0.resp_valid, bus0.req_ready, busy0);
    end
    @(posedge clk);
    @(negedge clk);
    bus0.req_valid = 1'b0;
    checks++;
    if (bus0.resp_valid !== 1'b0 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_read_accept: valid=%b busy=%b, want 0 1", bus0.resp_valid, busy0);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus0.resp_valid !== 1'b1 || bus0.resp_rdata !== 32'hA5A5A5A5 || bus0.resp_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_read_resp: valid=%b rdata=%h err=%b, want 1 a5a5a5a5 0",
               bus0.resp_valid, bus0.resp_rdata, bus0.resp_err);
    end
    @(posedge clk);
    @(negedge clk);
    bus0.resp_ready = 1'b0;
    checks++;
    if (bus0.resp_valid !== 1'b0 || bus0.resp_rdata !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL b2b_rdata_hold: valid=%b rdata=%h, want 0 a5a5a5a5",
               bus0.resp_valid, bus0.resp_rdata);
    end
  endtask

  initial begin
    bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_addr = 32'd0; bus2.req_wdata = 32'd0;
    bus2.resp_ready = 1'b0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = 32'd0; bus0.req_wdata = 32'd0;
    bus0.resp_ready = 1'b0;
    test_reset();
    test_write_read();
    test_backpressure();
    test_errors();
    test_reset_in_wait();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
